dram_traffic_checker: RTL and testbench
=======================================

// Module: dram_traffic_checker
// PURPOSE
//  Self-checking DRAM traffic engine on the addr_dram/din_dram/rw_dram/valid_dram/dout_dram/ready_dram port.
//  On start it writes NUM_WORDS generated words from start_addr at stride STRIDE, then reads them back and compares.
//  Parametrised successor to the single write/read DRAM stimulus: configurable width, length, stride and pattern mode.
//  Sits between board-level control (buttons/UART) and the DRAM controller top; results drive LEDs/debug.
// PARAMETERS
//  ADDR_W     27      DRAM word address width
//  DATA_W     32      DRAM data width
//  NUM_WORDS  256     words per pass (>=1)
//  STRIDE     1       address increment per word
//  TIMEOUT    4096    max cycles a request waits for ready_dram before abort
//  ERR_W      16      error counter width (saturating)
// PORTS
//  clk            in   1       system clock (single clock domain)
//  rst            in   1       synchronous reset, active-high
//  start          in   1       one-cycle pulse; honoured only in IDLE/DONE
//  mode           in   2       pattern: 0 const seed, 1 seed+i, 2 LFSR from seed, 3 data=addr (zero-extended/truncated)
//  seed           in   DATA_W  pattern seed; sampled on accepted start
//  start_addr     in   ADDR_W  first address; sampled on accepted start
//  addr_dram      out  ADDR_W  request address
//  din_dram       out  DATA_W  write data
//  rw_dram        out  1       1 = write, 0 = read
//  valid_dram     out  1       request valid
//  dout_dram      in   DATA_W  read data, valid in the cycle ready_dram=1 for a read
//  ready_dram     in   1       request completes in any cycle with valid_dram && ready_dram
//  busy           out  1       high in WRITE/READ
//  done           out  1       level; high in DONE until next accepted start or rst
//  pass           out  1       done && err_count==0 && !timeout
//  timeout        out  1       sticky; set when a request waits TIMEOUT cycles
//  err_count      out  ERR_W   read mismatches, saturates at all-ones
//  first_err_addr out  ADDR_W  address of first mismatch (0 if none)
//  first_err_data out  DATA_W  dout_dram of first mismatch (0 if none)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters 0. rst mid-transaction drops valid_dram the next edge; no completion pending.
//  States: IDLE -start-> WRITE -last write handshake-> READ -last read handshake-> DONE -start-> WRITE.
//   Any state -timeout-> DONE (timeout=1, valid_dram=0).
//  Accepted start: clears err_count/first_err_*/timeout/done, latches seed/start_addr/mode; valid_dram=1, rw=1 next cycle.
//  Request held stable (addr/din/rw/valid) until handshake; ready_dram without valid_dram is ignored.
//  After a handshake the next request is presented in the next cycle, valid stays high (no bubble).
//  WRITE->READ: first read request (rw=0, addr=start_addr) follows directly after final write handshake.
//  Address i = start_addr + i*STRIDE modulo 2^ADDR_W (wraps silently).
//  Pattern regenerated for READ phase from latched seed; LFSR: 32-bit Galois, taps 0x80200003, seed 0 replaced by 1;
//   for DATA_W != 32 the LFSR is DATA_W wide with the low taps truncated per package constant.
//  Compare in the read handshake cycle; err_count/first_err_* update on the following edge.
//  done rises the cycle after the final read handshake (so err_count is final when done=1).
//  Wait counter resets on every handshake; reaching TIMEOUT-1 while waiting -> timeout.
//  start while busy ignored; start and rst together: rst wins.
//  NUM_WORDS=1: exactly one write, one read.
// STRUCTURE
//  Package dram_traffic_pkg: mode encodings, state enum, LFSR tap constant.
//  Sub-module dram_pattern_gen: seed load, advance strobe, mode mux; instanced once, reloaded at phase change.
//  Top: FSM, word/addr counters, wait counter, compare/error capture.
// TESTING
//  Ideal DRAM model (ready 1 cycle after valid), mode=1 seed=0x10, NUM_WORDS=4 -> writes 0x10..0x13, done, pass=1, err=0.
//  Model corrupts read of addr 2 to 0xDEADBEEF, mode=0 -> err_count=1, first_err_addr=start+2, first_err_data=0xDEADBEEF.
//  start_addr=0x7FFFFFE, STRIDE=1, NUM_WORDS=4 -> addresses 0x7FFFFFE,0x7FFFFFF,0x0,0x1; pass=1.
//  ready_dram held 0, TIMEOUT=16 -> timeout=1, done=1, pass=0, valid_dram=0 after 16 cycles.
//  rst pulsed during READ, then start mode=2 -> clean restart, all outputs 0 after rst, LFSR sequence repeats, pass=1.
//  Random ready latency 0-5 cycles, start pulsed while busy -> ignored; addr/din stable until each handshake.

Source files
------------

// File: rtl/dram_traffic_pkg.sv
// Shared encodings for the DRAM traffic checker: pattern modes, FSM states and LFSR taps.
package dram_traffic_pkg;

  typedef enum logic [1:0] {
    MODE_CONST = 2'd0,
    MODE_INCR  = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_ADDR  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // 32-bit Galois taps; narrower data widths keep the low taps plus the top bit.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

endpackage

// File: rtl/dram_pattern_gen.sv
// Data pattern source: loads seed/mode on start, replays from the latched seed on restart,
// steps one word per advance strobe.
module dram_pattern_gen
  import dram_traffic_pkg::*;
#(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              restart,
  input  logic              advance,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  function automatic logic [DATA_W-1:0] taps_for_width();
    logic [DATA_W-1:0] t;
    t = '0;
    for (int i = 0; i < DATA_W && i < 32; i++) t[i] = LFSR_TAPS[i];
    t[DATA_W-1] = 1'b1;
    return t;
  endfunction

  localparam logic [DATA_W-1:0] TAPS = taps_for_width();

  function automatic logic [DATA_W-1:0] lfsr_init(input logic [DATA_W-1:0] s);
    return (s == '0) ? DATA_W'(1) : s;
  endfunction

  function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] x);
    return x[0] ? ((x >> 1) ^ TAPS) : (x >> 1);
  endfunction

  mode_e             mode_q;
  logic [DATA_W-1:0] seed_q;
  logic [DATA_W-1:0] incr_q;
  logic [DATA_W-1:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_CONST;
      seed_q <= '0;
      incr_q <= '0;
      lfsr_q <= '0;
    end else if (load) begin
      mode_q <= mode_e'(mode);
      seed_q <= seed;
      incr_q <= seed;
      lfsr_q <= lfsr_init(seed);
    end else if (restart) begin
      incr_q <= seed_q;
      lfsr_q <= lfsr_init(seed_q);
    end else if (advance) begin
      incr_q <= incr_q + DATA_W'(1);
      lfsr_q <= lfsr_step(lfsr_q);
    end
  end

  always_comb begin
    data = seed_q;
    case (mode_q)
      MODE_CONST: data = seed_q;
      MODE_INCR:  data = incr_q;
      MODE_LFSR:  data = lfsr_q;
      MODE_ADDR:  data = DATA_W'(addr);
      default:    data = seed_q;
    endcase
  end

endmodule

// File: rtl/dram_traffic_checker.sv
// Self-checking DRAM traffic engine: writes NUM_WORDS pattern words at a stride, reads them back
// and records mismatches. Request handshake: a request completes on any edge with valid && ready.
module dram_traffic_checker
  import dram_traffic_pkg::*;
#(
  parameter int ADDR_W    = 27,
  parameter int DATA_W    = 32,
  parameter int NUM_WORDS = 256,
  parameter int STRIDE    = 1,
  parameter int TIMEOUT   = 4096,
  parameter int ERR_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] addr_dram,
  output logic [DATA_W-1:0] din_dram,
  output logic              rw_dram,
  output logic              valid_dram,
  input  logic [DATA_W-1:0] dout_dram,
  input  logic              ready_dram,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data,
  output state_e            dbg_state
);

  localparam int IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  state_e            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [WAIT_W-1:0] wait_q;
  logic [ADDR_W-1:0] start_addr_q;
  logic [DATA_W-1:0] pat_data;
  logic              start_ok;
  logic              hs;
  logic              last_word;
  logic              gen_restart;
  logic              gen_advance;

  assign start_ok    = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign hs          = valid_dram && ready_dram;
  assign last_word   = (idx_q == IDX_W'(NUM_WORDS - 1));
  assign gen_restart = hs && last_word && (state_q == ST_WRITE);
  assign gen_advance = hs && !last_word;

  dram_pattern_gen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_pattern (
    .clk     (clk),
    .rst     (rst),
    .load    (start_ok),
    .restart (gen_restart),
    .advance (gen_advance),
    .mode    (mode),
    .seed    (seed),
    .addr    (addr_dram),
    .data    (pat_data)
  );

  // Write data and read expectation share the pattern output; it only moves on a handshake.
  assign din_dram  = pat_data;
  assign busy      = (state_q == ST_WRITE) || (state_q == ST_READ);
  assign pass      = done && (err_count == '0) && !timeout;
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      wait_q         <= '0;
      start_addr_q   <= '0;
      addr_dram      <= '0;
      rw_dram        <= 1'b0;
      valid_dram     <= 1'b0;
      done           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q        <= ST_WRITE;
            idx_q          <= '0;
            wait_q         <= '0;
            start_addr_q   <= start_addr;
            addr_dram      <= start_addr;
            rw_dram        <= 1'b1;
            valid_dram     <= 1'b1;
            done           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
          end
        end
        ST_WRITE, ST_READ: begin
          if (hs) begin
            wait_q <= '0;
            if (state_q == ST_READ && dout_dram != pat_data) begin
              if (err_count == '0) begin
                first_err_addr <= addr_dram;
                first_err_data <= dout_dram;
              end
              if (err_count != '1) err_count <= err_count + ERR_W'(1);
            end
            if (last_word) begin
              idx_q <= '0;
              if (state_q == ST_WRITE) begin
                state_q   <= ST_READ;
                rw_dram   <= 1'b0;
                addr_dram <= start_addr_q;
              end else begin
                state_q    <= ST_DONE;
                valid_dram <= 1'b0;
                done       <= 1'b1;
              end
            end else begin
              idx_q     <= idx_q + IDX_W'(1);
              addr_dram <= addr_dram + ADDR_W'(STRIDE);
            end
          end else if (valid_dram) begin
            // A request stalled for TIMEOUT cycles aborts the whole pass.
            if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
              state_q    <= ST_DONE;
              valid_dram <= 1'b0;
              timeout    <= 1'b1;
              done       <= 1'b1;
            end else begin
              wait_q <= wait_q + WAIT_W'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_traffic_checker.sv
// Directed bench for dram_traffic_checker: table of full passes against a DRAM model,
// plus hand-written timeout, reset-in-READ and start/rst corner sequences.
module tb_dram_traffic_checker;
  import dram_traffic_pkg::*;

  localparam int ADDR_W    = 27;
  localparam int DATA_W    = 32;
  localparam int NUM_WORDS = 4;
  localparam int STRIDE    = 1;
  localparam int TIMEOUT   = 16;
  localparam int ERR_W     = 16;
  localparam int SB_W      = 1 + ADDR_W + DATA_W;
  localparam int LAT_FIXED = 0;
  localparam int LAT_RAND  = 1;
  localparam int LAT_HOLD0 = 2;
  localparam logic [DATA_W-1:0] BAD_WORD = 32'hDEAD_BEEF;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic [DATA_W-1:0] seed = '0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W-1:0] addr_dram;
  logic [DATA_W-1:0] din_dram;
  logic              rw_dram;
  logic              valid_dram;
  logic [DATA_W-1:0] dout_dram = '0;
  logic              ready_dram = 1'b0;
  logic              busy;
  logic              done;
  logic              pass;
  logic              timeout;
  logic [ERR_W-1:0]  err_count;
  logic [ADDR_W-1:0] first_err_addr;
  logic [DATA_W-1:0] first_err_data;
  state_e            dbg_state;

  dram_traffic_checker #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .NUM_WORDS (NUM_WORDS),
    .STRIDE    (STRIDE),
    .TIMEOUT   (TIMEOUT),
    .ERR_W     (ERR_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .mode           (mode),
    .seed           (seed),
    .start_addr     (start_addr),
    .addr_dram      (addr_dram),
    .din_dram       (din_dram),
    .rw_dram        (rw_dram),
    .valid_dram     (valid_dram),
    .dout_dram      (dout_dram),
    .ready_dram     (ready_dram),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .timeout        (timeout),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .first_err_data (first_err_data),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]        mode;
    logic [DATA_W-1:0] seed;
    logic [ADDR_W-1:0] start_addr;
    int                lat_kind;
    int                lat;
    logic [3:0]        corrupt_mask;
    logic              busy_poke;
    int                exp_err;
    logic [ADDR_W-1:0] exp_faddr;
    logic [DATA_W-1:0] exp_fdata;
    logic              exp_pass;
  } vec_t;

  vec_t vecs[6];

  // ---------------- scoreboard / counters ----------------
  int               n_checks = 0;
  int               n_errors = 0;
  logic [SB_W-1:0]  exp_q[$];

  // ---------------- DRAM model state ----------------
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
  int                lat_kind = LAT_FIXED;
  int                fixed_lat = 0;
  int                cur_lat = 0;
  int                wcnt = 0;
  logic [ADDR_W-1:0] corr_base = '0;
  logic [3:0]        corr_mask = '0;
  int                edge_cnt = 0;
  int                last_rd_edge = -1;
  logic              pend = 1'b0;
  logic              hs_seen = 1'b0;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_din;
  logic              h_rw;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_word(input logic [1:0] m, input logic [DATA_W-1:0] s,
                                                 input int i, input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] x;
    case (m)
      2'd0: return s;
      2'd1: return s + DATA_W'(i);
      2'd2: begin
        x = (s == '0) ? DATA_W'(1) : s;
        for (int k = 0; k < i; k++) x = x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
        return x;
      end
      default: return DATA_W'(a);
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base, input int i);
    return base + ADDR_W'(i * STRIDE);
  endfunction

  function automatic int next_lat();
    return (lat_kind == LAT_RAND) ? int'($urandom_range(0, 5)) : fixed_lat;
  endfunction

  task automatic push_exp(input vec_t v);
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < NUM_WORDS; i++) begin
      a = word_addr(v.start_addr, i);
      exp_q.push_back({1'b1, a, exp_word(v.mode, v.seed, i, a)});
    end
    for (int i = 0; i < NUM_WORDS; i++) begin
      a = word_addr(v.start_addr, i);
      exp_q.push_back({1'b0, a, DATA_W'(0)});
    end
  endtask

  // Handshake monitor: memory update and scoreboard pop, sampled on the active edge.
  always @(posedge clk) begin
    logic [SB_W-1:0] e;
    edge_cnt++;
    if (valid_dram && ready_dram && !rst) begin
      hs_seen = 1'b1;
      wcnt    = 0;
      cur_lat = next_lat();
      if (rw_dram) mem[addr_dram] = din_dram;
      if (exp_q.size() == 0) begin
        chk("unexpected_handshake", {63'd0, 1'b1}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("hs_rw", {63'd0, rw_dram}, {63'd0, e[SB_W-1]});
        chk("hs_addr", {37'd0, addr_dram}, {37'd0, e[SB_W-2 -: ADDR_W]});
        if (rw_dram) chk("hs_wdata", {32'd0, din_dram}, {32'd0, e[DATA_W-1:0]});
        if (exp_q.size() == 0) last_rd_edge = edge_cnt;
      end
    end
  end

  // Responder: request-stability check and ready/dout drive, away from the active edge.
  always @(negedge clk) begin
    logic [ADDR_W-1:0] off;
    if (pend && !hs_seen && valid_dram && !rst) begin
      chk("stable_req", {addr_dram, din_dram, rw_dram}, {h_addr, h_din, h_rw});
    end
    pend    = valid_dram;
    h_addr  = addr_dram;
    h_din   = din_dram;
    h_rw    = rw_dram;
    hs_seen = 1'b0;
    if (!valid_dram) begin
      wcnt       = 0;
      ready_dram = 1'b0;
    end else begin
      ready_dram = (lat_kind != LAT_HOLD0) && (wcnt >= cur_lat);
      wcnt++;
      off = addr_dram - corr_base;
      if (!rw_dram && off < 4 && corr_mask[off[1:0]]) dout_dram = BAD_WORD;
      else if (mem.exists(addr_dram)) dout_dram = mem[addr_dram];
      else dout_dram = '0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_outputs_zero(input string tag);
    chk({tag, "_valid"}, {63'd0, valid_dram}, 64'd0);
    chk({tag, "_rw"}, {63'd0, rw_dram}, 64'd0);
    chk({tag, "_addr"}, {37'd0, addr_dram}, 64'd0);
    chk({tag, "_din"}, {32'd0, din_dram}, 64'd0);
    chk({tag, "_busy_done_pass_to"}, {60'd0, busy, done, pass, timeout}, 64'd0);
    chk({tag, "_err"}, {48'd0, err_count}, 64'd0);
    chk({tag, "_ferr"}, {5'd0, first_err_addr, first_err_data}, 64'd0);
    chk({tag, "_state"}, {62'd0, dbg_state}, {62'd0, ST_IDLE});
  endtask

  task automatic pulse_start(input vec_t v);
    mode       = v.mode;
    seed       = v.seed;
    start_addr = v.start_addr;
    lat_kind   = v.lat_kind;
    fixed_lat  = v.lat;
    cur_lat    = next_lat();
    corr_base  = v.start_addr;
    corr_mask  = v.corrupt_mask;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic run_test(input vec_t v, input string tag);
    bit got_done;
    push_exp(v);
    last_rd_edge = -1;
    @(negedge clk);
    pulse_start(v);
    chk({tag, "_first_req"}, {60'd0, valid_dram, rw_dram, busy, done}, {60'd0, 4'b1110});
    chk({tag, "_first_addr"}, {37'd0, addr_dram}, {37'd0, v.start_addr});
    got_done = 1'b0;
    for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
      if (v.busy_poke && cyc == 3) begin
        start = 1'b1; seed = ~v.seed; start_addr = v.start_addr ^ 27'h55; mode = ~v.mode;
      end
      if (v.busy_poke && cyc == 4) begin
        start = 1'b0; seed = v.seed; start_addr = v.start_addr; mode = v.mode;
      end
      @(negedge clk);
      if (done) got_done = 1'b1;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, {63'd0, got_done}, 64'd1);
    chk({tag, "_done_timing"}, 64'(edge_cnt), 64'(last_rd_edge));
    chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_err"}, {48'd0, err_count}, 64'(v.exp_err));
    chk({tag, "_ferr"}, {5'd0, first_err_addr, first_err_data}, {5'd0, v.exp_faddr, v.exp_fdata});
    chk({tag, "_flags"}, {60'd0, pass, timeout, busy, valid_dram}, {60'd0, v.exp_pass, 3'b000});
    exp_q.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int   vcnt;
    bit   in_read;
    vec_t v;

    vecs[0] = '{2'd1, 32'h0000_0010, 27'h0000100, LAT_FIXED, 0, 4'b0000, 1'b0, 0, 27'h0, 32'h0, 1'b1};
    vecs[1] = '{2'd0, 32'hA5A5_A5A5, 27'h0000200, LAT_FIXED, 0, 4'b0100, 1'b0, 1, 27'h0000202, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{2'd3, 32'h0000_0000, 27'h7FFFFFE, LAT_RAND, 0, 4'b0000, 1'b0, 0, 27'h0, 32'h0, 1'b1};
    vecs[3] = '{2'd2, 32'h0000_0000, 27'h0000040, LAT_RAND, 0, 4'b0000, 1'b1, 0, 27'h0, 32'h0, 1'b1};
    vecs[4] = '{2'd2, 32'h1234_5678, 27'h0001000, LAT_FIXED, 3, 4'b0000, 1'b0, 0, 27'h0, 32'h0, 1'b1};
    vecs[5] = '{2'd1, 32'hFFFF_FFFE, 27'h0000000, LAT_FIXED, 1, 4'b1010, 1'b1, 2, 27'h0000001, 32'hDEAD_BEEF, 1'b0};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("idle");

    for (int i = 0; i < 6; i++) run_test(vecs[i], $sformatf("vec%0d", i));

    // ready held low: the first write must abort after TIMEOUT cycles of valid.
    v = '{2'd1, 32'h0, 27'h0000300, LAT_HOLD0, 0, 4'b0000, 1'b0, 0, 27'h0, 32'h0, 1'b0};
    @(negedge clk);
    pulse_start(v);
    vcnt = 0;
    for (int cyc = 0; cyc < 40 && valid_dram; cyc++) begin
      vcnt++;
      @(negedge clk);
    end
    chk("to_valid_cycles", 64'(vcnt), 64'(TIMEOUT));
    chk("to_flags", {59'd0, timeout, done, pass, busy, valid_dram}, {59'd0, 5'b11000});
    chk("to_err", {48'd0, err_count}, 64'd0);
    lat_kind = LAT_FIXED;

    // A fresh start after a timeout clears the sticky flag.
    run_test(vecs[0], "after_to");

    // Reset in the middle of the READ phase, then a clean LFSR pass.
    v = '{2'd2, 32'h0000_CAFE, 27'h0000500, LAT_RAND, 0, 4'b0000, 1'b0, 0, 27'h0, 32'h0, 1'b1};
    push_exp(v);
    @(negedge clk);
    pulse_start(v);
    in_read = 1'b0;
    for (int cyc = 0; cyc < 200 && !in_read; cyc++) begin
      @(negedge clk);
      if (valid_dram && !rw_dram) in_read = 1'b1;
    end
    chk("rst_reached_read", {63'd0, in_read}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("mid_rst");
    rst = 1'b0;
    exp_q.delete();
    run_test(v, "post_rst");

    // start and rst together: reset wins.
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    check_outputs_zero("rst_start");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
